// File: rtl/serial_sum_collector_if.sv
// Bit-serial input and word-output handshake bundle for serial_sum_collector.
interface serial_sum_collector_if #(
    parameter int WIDTH = 8
);
    logic             bit_in;
    logic             bit_valid;
    logic             bit_first;
    logic             carry_in;
    logic             bit_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_carry;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output bit_in, bit_valid, bit_first, carry_in, out_ready,
        input  bit_ready, out_data, out_carry, out_valid
    );

    modport slave (
        input  bit_in, bit_valid, bit_first, carry_in, out_ready,
        output bit_ready, out_data, out_carry, out_valid
    );
endinterface

// File: rtl/serial_sum_collector.sv
// Collects LSB-first serial sum bits into WIDTH-bit words (plus final carry)
// and queues them in a small output FIFO.
module serial_sum_collector #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    serial_sum_collector_if.slave bus,
    output logic                 overflow_err,
    output logic                 framing_err,
    output logic [7:0]           word_count
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
    localparam logic [PW:0]   FULL_OCC = (PW + 1)'(DEPTH);

    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] asm_reg;
    logic [WIDTH:0]   mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      occ;

    logic             ready_int;
    logic             valid_int;
    logic             accept;
    logic             push;
    logic             pop;
    logic [CW-1:0]    cnt_base;
    logic [WIDTH-2:0] upper_bits;
    logic [WIDTH-1:0] next_word;
    logic [WIDTH:0]   head;

    always_comb begin
        ready_int  = (occ != FULL_OCC);
        valid_int  = (occ != '0);
        accept     = bus.bit_valid && ready_int;
        // bit_first restarts assembly: the current bit is treated as bit 0
        cnt_base   = bus.bit_first ? '0 : bit_cnt;
        upper_bits = bus.bit_first ? '0 : asm_reg[WIDTH-1:1];
        next_word  = {bus.bit_in, upper_bits};
        push       = accept && (cnt_base == LAST_IDX);
        pop        = valid_int && bus.out_ready;
        head       = mem[rd_ptr];
    end

    assign bus.bit_ready = ready_int;
    assign bus.out_valid = valid_int;
    assign bus.out_data  = valid_int ? head[WIDTH-1:0] : '0;
    assign bus.out_carry = valid_int ? head[WIDTH] : 1'b0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bit_cnt      <= '0;
            asm_reg      <= '0;
            overflow_err <= 1'b0;
            framing_err  <= 1'b0;
            word_count   <= '0;
        end else begin
            if (bus.bit_valid && !ready_int)
                overflow_err <= 1'b1;
            if (accept) begin
                asm_reg <= next_word;
                bit_cnt <= push ? '0 : cnt_base + CW'(1);
                if (bus.bit_first && (bit_cnt != '0))
                    framing_err <= 1'b1;
            end
            if (push)
                word_count <= word_count + 8'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {bus.carry_in, next_word};
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   occ <= occ + (PW + 1)'(1);
                2'b01:   occ <= occ - (PW + 1)'(1);
                default: occ <= occ;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_sum_collector.sv
// Randomized scoreboard bench for serial_sum_collector against a word-level
// reference model.
module tb_serial_sum_collector;
    localparam int WIDTH = 8;
    localparam int DEPTH = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       overflow_err;
    logic       framing_err;
    logic [7:0] word_count;

    int checks   = 0;
    int failures = 0;
    bit rand_ready = 0;

    serial_sum_collector_if #(.WIDTH(WIDTH)) bus ();

    serial_sum_collector #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock        (clock),
        .reset        (reset),
        .bus          (bus),
        .overflow_err (overflow_err),
        .framing_err  (framing_err),
        .word_count   (word_count)
    );

    always #5 clock = ~clock;

    // Reference model: words are built by bit position, queued as {carry, data}
    logic [8:0] exp_q[$];
    int         m_occ;
    int         m_pos;
    logic [7:0] m_acc;
    logic       m_ovf;
    logic       m_frm;
    logic [7:0] m_wc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clock or posedge reset) begin : model
        bit do_pop;
        bit do_push;
        if (reset) begin
            exp_q.delete();
            m_occ = 0; m_pos = 0; m_acc = 8'h00;
            m_ovf = 0; m_frm = 0; m_wc = 8'h00;
        end else begin
            do_pop  = (m_occ > 0) && bus.out_ready;
            do_push = 0;
            if (bus.bit_valid) begin
                if (m_occ >= DEPTH) begin
                    m_ovf = 1;
                end else begin
                    if (bus.bit_first) begin
                        if (m_pos != 0) m_frm = 1;
                        m_pos = 0;
                        m_acc = 8'h00;
                    end
                    m_acc[m_pos] = bus.bit_in;
                    if (m_pos == WIDTH - 1) begin
                        exp_q.push_back({bus.carry_in, m_acc});
                        m_wc    = m_wc + 8'd1;
                        m_pos   = 0;
                        do_push = 1;
                    end else begin
                        m_pos = m_pos + 1;
                    end
                end
            end
            m_occ = m_occ + int'(do_push) - int'(do_pop);
        end
    end

    always @(negedge clock) begin : monitor
        if (!reset) begin
            check("out_valid", bus.out_valid, m_occ != 0);
            check("bit_ready", bus.bit_ready, m_occ < DEPTH);
            check("overflow_err", overflow_err, m_ovf);
            check("framing_err", framing_err, m_frm);
            check("word_count", word_count, m_wc);
            if (exp_q.size() > 0) begin
                check("out_data", bus.out_data, exp_q[0][7:0]);
                check("out_carry", bus.out_carry, exp_q[0][8]);
                if (bus.out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
        if (rand_ready) bus.out_ready = 1'($urandom % 2);
    endtask

    task automatic drive_bit(input logic b, input logic first, input logic carry);
        bus.bit_valid = 1'b1;
        bus.bit_in    = b;
        bus.bit_first = first;
        bus.carry_in  = carry;
        tick();
        bus.bit_valid = 1'b0;
        bus.bit_in    = 1'b0;
        bus.bit_first = 1'b0;
        bus.carry_in  = 1'b0;
    endtask

    // carry_in is randomized on non-final bits since only the last one matters
    task automatic send_word(input logic [7:0] d, input logic c, input logic first, input int gap_max);
        for (int i = 0; i < WIDTH; i++) begin
            drive_bit(d[i], first && (i == 0), (i == WIDTH - 1) ? c : 1'($urandom % 2));
            if (gap_max > 0) repeat ($urandom_range(0, gap_max)) tick();
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clock);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_data", bus.out_data, 8'h00);
        check("rst_out_carry", bus.out_carry, 1'b0);
        check("rst_bit_ready", bus.bit_ready, 1'b1);
        check("rst_overflow", overflow_err, 1'b0);
        check("rst_framing", framing_err, 1'b0);
        check("rst_word_count", word_count, 8'h00);
        tick();
        reset = 1'b0;
    endtask

    initial begin
        logic [7:0] w;
        bus.bit_in = 0; bus.bit_valid = 0; bus.bit_first = 0;
        bus.carry_in = 0; bus.out_ready = 0;
        tick();
        do_reset();

        // Single word, immediate output
        bus.out_ready = 1'b1;
        send_word(8'h5A, 1'b1, 1'b1, 0);
        check("t1_valid", bus.out_valid, 1'b1);
        check("t1_data", bus.out_data, 8'h5A);
        check("t1_carry", bus.out_carry, 1'b1);
        check("t1_wc", word_count, 8'd1);
        tick();
        check("t1_valid_drop", bus.out_valid, 1'b0);

        // Fill FIFO, overflow word is dropped
        do_reset();
        bus.out_ready = 1'b0;
        send_word(8'h11, 1'b0, 1'b1, 1);
        send_word(8'h22, 1'b1, 1'b1, 1);
        check("t2_full", bus.bit_ready, 1'b0);
        send_word(8'h33, 1'b1, 1'b1, 0);
        check("t2_ovf", overflow_err, 1'b1);
        bus.out_ready = 1'b1;
        check("t2_head0", bus.out_data, 8'h11);
        tick();
        check("t2_head1", bus.out_data, 8'h22);
        tick();
        check("t2_empty", bus.out_valid, 1'b0);

        // Framing error: partial word discarded
        do_reset();
        bus.out_ready = 1'b1;
        drive_bit(1'b1, 1'b1, 1'b0);
        drive_bit(1'b0, 1'b0, 1'b0);
        drive_bit(1'b1, 1'b0, 1'b0);
        send_word(8'hC3, 1'b0, 1'b1, 0);
        check("t3_frm", framing_err, 1'b1);
        check("t3_data", bus.out_data, 8'hC3);
        check("t3_wc", word_count, 8'd1);
        tick();

        // Simultaneous push and pop with one entry
        do_reset();
        bus.out_ready = 1'b0;
        send_word(8'h3C, 1'b0, 1'b1, 0);
        w = 8'hA5;
        for (int i = 0; i < WIDTH - 1; i++) drive_bit(w[i], i == 0, 1'b0);
        bus.out_ready = 1'b1;
        drive_bit(w[WIDTH-1], 1'b0, 1'b1);
        bus.out_ready = 1'b0;
        check("t4_valid", bus.out_valid, 1'b1);
        check("t4_ready", bus.bit_ready, 1'b1);
        check("t4_data", bus.out_data, 8'hA5);
        check("t4_carry", bus.out_carry, 1'b1);
        tick();

        // Reset mid-word with an entry queued
        do_reset();
        bus.out_ready = 1'b0;
        send_word(8'h96, 1'b1, 1'b1, 0);
        for (int i = 0; i < 5; i++) drive_bit(1'b1, i == 0, 1'b0);
        do_reset();
        bus.out_ready = 1'b1;
        send_word(8'hFF, 1'b0, 1'b0, 0);
        check("t5_data", bus.out_data, 8'hFF);
        check("t5_valid", bus.out_valid, 1'b1);
        tick();

        // word_count wrap
        do_reset();
        bus.out_ready = 1'b1;
        for (int n = 0; n < 256; n++) send_word(8'($urandom), 1'($urandom % 2), 1'b1, 0);
        check("t6_wrap", word_count, 8'd0);
        send_word(8'($urandom), 1'($urandom % 2), 1'b1, 0);
        check("t6_wrap1", word_count, 8'd1);
        tick();

        // Randomized traffic with backpressure and occasional framing faults
        do_reset();
        rand_ready = 1;
        for (int n = 0; n < 300; n++) begin
            if ($urandom % 8 == 0) begin
                repeat ($urandom_range(1, 6)) drive_bit(1'($urandom % 2), 1'b0, 1'b0);
            end
            send_word(8'($urandom), 1'($urandom % 2), 1'($urandom % 4 != 0), 2);
        end

        rand_ready = 0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20 && m_occ != 0; i++) tick();
        tick();
        check("drain_empty", bus.out_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
